// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the combination-lock controller.
// State encodings are visible on state_o, so they must not be reordered.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        StLocked  = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StOpen    = 3'd3,
        StLockout = 3'd4
    } state_t;

    localparam int unsigned CODE_W_DEF      = 16;
    localparam int unsigned NUM_ENTRIES_DEF = 3;
    localparam int unsigned MAX_TRIES_DEF   = 3;

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES_DEF + 1);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES_DEF + 1);

    // Entry 0 sits in the most significant word.
    localparam logic [NUM_ENTRIES_DEF*CODE_W_DEF-1:0] DEF_CODE = 48'h1234_5678_9ABC;

endpackage

// File: rtl/press_conditioner.sv
// Button conditioner: 2-FF synchronizer, counter debounce and a one-cycle
// pulse on every accepted 0->1 transition of the debounced level.
module press_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample;
    logic             w_accept;

    assign w_sample = r_sync[1];
    // The DEBOUNCE_CYCLES-th consecutive sample differing from the current level flips it.
    assign w_accept = (w_sample != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], raw_in};
            r_pulse <= w_accept & w_sample;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= w_sample;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign pulse_o = r_pulse;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: entry capture, code check, unlock, tries and lockout.
// Optional macro COMBO_LOCK_PROGRAM_EN enables re-programming the code from OPEN.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int unsigned                   CODE_W          = CODE_W_DEF,
    parameter int unsigned                   NUM_ENTRIES     = NUM_ENTRIES_DEF,
    parameter logic [NUM_ENTRIES*CODE_W-1:0] DEFAULT_CODE    = DEF_CODE,
    parameter int unsigned                   MAX_TRIES       = MAX_TRIES_DEF,
    parameter int unsigned                   DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned                   LOCKOUT_CYCLES  = 500_000_000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               press,
    input  logic [CODE_W-1:0]                  switch,
    input  logic                               relock,
    output logic                               unlocked,
    output logic                               alarm,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   entry_idx,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic [2:0]                         state_o
);

    localparam int unsigned ENT_W     = $clog2(NUM_ENTRIES + 1);
    localparam int unsigned TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_W   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned CODE_BITS = NUM_ENTRIES * CODE_W;

    state_t               r_state, w_state_d;
    logic [ENT_W-1:0]     r_entry_idx, w_entry_idx_d;
    logic [TRIES_W-1:0]   r_tries, w_tries_d;
    logic                 r_mismatch, w_mismatch_d;
    logic [TIMER_W-1:0]   r_timer, w_timer_d;
    logic                 r_unlocked, r_alarm;
    logic [CODE_BITS-1:0] w_code;
    logic [CODE_W-1:0]    w_word;
    logic                 w_press_level, w_press_pulse, w_press;

    press_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_press (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (press),
        .level_o(w_press_level),
        .pulse_o(w_press_pulse)
    );

    assign w_press = w_press_pulse & w_press_level;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_entry_idx == ENT_W'(i)) w_word = w_code[(NUM_ENTRIES-1-i)*CODE_W +: CODE_W];
        end
    end

`ifdef COMBO_LOCK_PROGRAM_EN
    logic [CODE_BITS-1:0] r_code, w_code_d;

    always_comb begin
        w_code_d = r_code;
        if (r_state == StOpen && !relock && w_press) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_entry_idx == ENT_W'(i)) w_code_d[(NUM_ENTRIES-1-i)*CODE_W +: CODE_W] = switch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_code <= DEFAULT_CODE;
        else        r_code <= w_code_d;
    end

    assign w_code = r_code;
`else
    assign w_code = DEFAULT_CODE;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_entry_idx_d = r_entry_idx;
        w_tries_d     = r_tries;
        w_mismatch_d  = r_mismatch;
        w_timer_d     = r_timer;
        case (r_state)
            // Every word is collected before judging, so a wrong word is never revealed early.
            StLocked, StEntry: begin
                if (w_press) begin
                    w_mismatch_d  = r_mismatch | (switch != w_word);
                    w_entry_idx_d = r_entry_idx + 1'b1;
                    w_state_d     = (r_entry_idx == ENT_W'(NUM_ENTRIES - 1)) ? StCheck : StEntry;
                end
            end
            StCheck: begin
                w_entry_idx_d = '0;
                w_mismatch_d  = 1'b0;
                if (!r_mismatch) begin
                    w_state_d = StOpen;
                    w_tries_d = TRIES_W'(MAX_TRIES);
                end else if (r_tries > TRIES_W'(1)) begin
                    w_state_d = StLocked;
                    w_tries_d = r_tries - 1'b1;
                end else begin
                    w_state_d = StLockout;
                    w_tries_d = '0;
                    w_timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
                end
            end
            StOpen: begin
                if (relock) begin
                    w_state_d     = StLocked;
                    w_entry_idx_d = '0;
                end
`ifdef COMBO_LOCK_PROGRAM_EN
                else if (w_press) begin
                    if (r_entry_idx == ENT_W'(NUM_ENTRIES - 1)) begin
                        w_state_d     = StLocked;
                        w_entry_idx_d = '0;
                    end else begin
                        w_entry_idx_d = r_entry_idx + 1'b1;
                    end
                end
`endif
            end
            StLockout: begin
                if (r_timer == '0) begin
                    w_state_d = StLocked;
                    w_tries_d = TRIES_W'(MAX_TRIES);
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            default: w_state_d = StLocked;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StLocked;
            r_entry_idx <= '0;
            r_tries     <= TRIES_W'(MAX_TRIES);
            r_mismatch  <= 1'b0;
            r_timer     <= '0;
            r_unlocked  <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_entry_idx <= w_entry_idx_d;
            r_tries     <= w_tries_d;
            r_mismatch  <= w_mismatch_d;
            r_timer     <= w_timer_d;
            r_unlocked  <= (w_state_d == StOpen);
            r_alarm     <= (w_state_d == StLockout);
        end
    end

    assign unlocked   = r_unlocked;
    assign alarm      = r_alarm;
    assign entry_idx  = r_entry_idx;
    assign tries_left = r_tries;
    assign state_o    = r_state;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl against an attempt-level lock model.
// Define COMBO_LOCK_PROGRAM_EN for both bench and RTL to exercise code programming.
module tb_combo_lock_ctrl;

    localparam int unsigned N  = 3;
    localparam int unsigned MT = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned LO = 20;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        press  = 1'b0;
    logic        relock = 1'b0;
    logic [15:0] switch = 16'h0000;
    logic        unlocked, alarm;
    logic [1:0]  entry_idx, tries_left;
    logic [2:0]  state_o;
    logic [9:0]  observed;

    int checks      = 0;
    int errors      = 0;
    int alarm_total = 0;

    // Lock model: the code as an array of words, the words of the attempt in progress as a queue.
    logic [15:0] m_code[N];
    logic [15:0] m_q[$];
    int          m_tries;
    logic        m_open;
    logic        m_lock;
    int          m_pidx;

    combo_lock_ctrl #(
        .CODE_W         (16),
        .NUM_ENTRIES    (N),
        .DEFAULT_CODE   (48'h1234_5678_9ABC),
        .MAX_TRIES      (MT),
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press     (press),
        .switch    (switch),
        .relock    (relock),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .entry_idx (entry_idx),
        .tries_left(tries_left),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (alarm === 1'b1) alarm_total++;

    assign observed = {unlocked, alarm, entry_idx, tries_left, state_o};

    function automatic logic [9:0] expected();
        int st;
        int idx;
        if (m_lock) st = 4;
        else if (m_open) st = 3;
        else if (m_q.size() > 0) st = 1;
        else st = 0;
        idx = m_open ? m_pidx : m_q.size();
        return {m_open, m_lock, 2'(idx), 2'(m_tries), 3'(st)};
    endfunction

    task automatic model_reset();
        m_code[0] = 16'h1234;
        m_code[1] = 16'h5678;
        m_code[2] = 16'h9ABC;
        m_q.delete();
        m_tries = MT;
        m_open  = 1'b0;
        m_lock  = 1'b0;
        m_pidx  = 0;
    endtask

    task automatic model_press(input logic [15:0] sw);
        bit ok;
        if (m_lock) return;
        if (m_open) begin
`ifdef COMBO_LOCK_PROGRAM_EN
            m_code[m_pidx] = sw;
            m_pidx++;
            if (m_pidx == N) begin
                m_pidx = 0;
                m_open = 1'b0;
            end
`endif
            return;
        end
        m_q.push_back(sw);
        if (m_q.size() == N) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
            m_q.delete();
            if (ok) begin
                m_open  = 1'b1;
                m_tries = MT;
            end else begin
                m_tries--;
                if (m_tries == 0) m_lock = 1'b1;
            end
        end
    endtask

    task automatic do_press(input logic [15:0] sw, input int hold, input int rel);
        @(posedge clk);
        #1;
        switch = sw;
        press  = 1'b1;
        repeat (hold) @(posedge clk);
        #1 press = 1'b0;
        repeat (rel) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_word(input logic [15:0] sw);
        do_press(sw, 10, 10);
        model_press(sw);
    endtask

    task automatic do_relock();
        @(posedge clk);
        #1 relock = 1'b1;
        @(posedge clk);
        #1 relock = 1'b0;
        @(negedge clk);
        if (m_open) begin
            m_open = 1'b0;
            m_pidx = 0;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL reset_hold: observed %b required %b", observed, expected());
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL reset_release: observed %b required %b", observed, expected());
        end
    endtask

    task automatic test_unlock();
        press_word(16'h1234);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL unlock_w0: observed %b required %b", observed, expected());
        end
        press_word(16'h5678);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL unlock_w1: observed %b required %b", observed, expected());
        end
        // Last word driven by hand to pin the 2 + DB + 2 cycle latency.
        @(posedge clk);
        #1;
        switch = 16'h9ABC;
        press  = 1'b1;
        repeat (2 + DB + 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL unlock_early: observed %b required 0", unlocked);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL unlock_latency: observed %b required 1", unlocked);
        end
        repeat (2) @(posedge clk);
        #1 press = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        model_press(16'h9ABC);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL unlock_open: observed %b required %b", observed, expected());
        end
        do_relock();
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL unlock_relock: observed %b required %b", observed, expected());
        end
    endtask

    task automatic test_glitch();
        do_press(16'h1234, DB - 1, 10);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL glitch_ignored: observed %b required %b", observed, expected());
        end
        @(posedge clk);
        #1;
        switch = 16'h1234;
        press  = 1'b1;
        repeat (8) @(posedge clk);
        #1 press = 1'b0;
        @(posedge clk);
        #1 press = 1'b1;
        repeat (8) @(posedge clk);
        #1 press = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        model_press(16'h1234);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL dropout_single: observed %b required %b", observed, expected());
        end
        press_word(16'h5678);
        press_word(16'h9ABC);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL dropout_open: observed %b required %b", observed, expected());
        end
        do_relock();
    endtask

    task automatic test_wrong();
        press_word(16'h1234);
        press_word(16'h0000);
        press_word(16'h9ABC);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL wrong_attempt: observed %b required %b", observed, expected());
        end
    endtask

    task automatic test_lockout();
        int a0;
        for (int i = 0; i < N; i++) press_word(16'h0000);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL lockout_second: observed %b required %b", observed, expected());
        end
        a0 = alarm_total;
        press_word(16'h1111);
        press_word(16'h2222);
        do_press(16'h3333, 8, 8);
        model_press(16'h3333);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL lockout_enter: observed %b required %b", observed, expected());
        end
        // Accepted mid-lockout and held past its end: must not be captured.
        do_press(16'h1234, 24, 10);
        m_lock  = 1'b0;
        m_tries = MT;
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL lockout_exit: observed %b required %b", observed, expected());
        end
        checks++;
        if (alarm_total - a0 != LO) begin
            errors++;
            $display("FAIL lockout_len: observed %0d required %0d", alarm_total - a0, LO);
        end
    endtask

    task automatic test_relock_press();
        for (int i = 0; i < N; i++) press_word(m_code[i]);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL relock_open: observed %b required %b", observed, expected());
        end
        // relock is raised for exactly the cycle the press pulse reaches the FSM.
        @(posedge clk);
        #1;
        switch = 16'h1111;
        press  = 1'b1;
        repeat (2 + DB) @(posedge clk);
        #1 relock = 1'b1;
        @(posedge clk);
        #1 relock = 1'b0;
        repeat (3) @(posedge clk);
        #1 press = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        m_open = 1'b0;
        m_pidx = 0;
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL relock_wins: observed %b required %b", observed, expected());
        end
    endtask

    task automatic test_reset_mid();
        press_word(16'h1234);
        press_word(16'h5678);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL midreset_before: observed %b required %b", observed, expected());
        end
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL midreset_async: observed %b required %b", observed, expected());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) press_word(m_code[i]);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL midreset_unlock: observed %b required %b", observed, expected());
        end
        do_relock();
    endtask

    task automatic test_random();
        logic [15:0] sw;
        int          n;
        bit          good;
        for (int a = 0; a < 10; a++) begin
            good = ($urandom_range(99, 0) < 40);
            for (int w = 0; w < N; w++) begin
                sw = (good || $urandom_range(99, 0) < 50) ? m_code[w] : 16'($urandom);
                press_word(sw);
                checks++;
                if (observed !== expected()) begin
                    errors++;
                    $display("FAIL random_a%0d_w%0d: observed %b required %b", a, w, observed,
                             expected());
                end
            end
            if (m_open) begin
                do_relock();
                checks++;
                if (observed !== expected()) begin
                    errors++;
                    $display("FAIL random_relock_a%0d: observed %b required %b", a, observed,
                             expected());
                end
            end else if (m_lock) begin
                n = 0;
                while (alarm === 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (2) @(negedge clk);
                m_lock  = 1'b0;
                m_tries = MT;
                checks++;
                if (observed !== expected()) begin
                    errors++;
                    $display("FAIL random_lockout_a%0d: observed %b required %b", a, observed,
                             expected());
                end
            end
        end
    endtask

`ifdef COMBO_LOCK_PROGRAM_EN
    task automatic test_program();
        logic [15:0] old_code[N];
        for (int i = 0; i < N; i++) old_code[i] = m_code[i];
        for (int i = 0; i < N; i++) press_word(m_code[i]);
        press_word(16'h1111);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL prog_w0: observed %b required %b", observed, expected());
        end
        press_word(16'h2222);
        press_word(16'h3333);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL prog_done: observed %b required %b", observed, expected());
        end
        do_relock();
        for (int i = 0; i < N; i++) press_word(old_code[i]);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL prog_old_fails: observed %b required %b", observed, expected());
        end
        press_word(16'h1111);
        press_word(16'h2222);
        press_word(16'h3333);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL prog_new_opens: observed %b required %b", observed, expected());
        end
        press_word(16'hAAAA);
        do_relock();
        for (int i = 0; i < N; i++) press_word(m_code[i]);
        checks++;
        if (observed !== expected()) begin
            errors++;
            $display("FAIL prog_abort_kept: observed %b required %b", observed, expected());
        end
        do_relock();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unlock();
        test_glitch();
        test_wrong();
        test_lockout();
        test_relock_press();
        test_reset_mid();
        test_random();
`ifdef COMBO_LOCK_PROGRAM_EN
        test_program();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
